// File: rtl/keypad_scan_debounce.sv
// Row-scanning keypad decoder with press/release debounce, chord rejection and key history.
// Optional macro KEYPAD_HEX_MAP_EN maps 4x4 key positions onto the printed keypad legend.
module keypad_scan_debounce #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_DIGITS      = 2,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COLS-1:0]          col_sync,
  output logic [ROWS-1:0]          r_sel,
  output logic                     key_valid,
  output logic [KW-1:0]            key_code,
  output logic                     key_held,
  output logic [NUM_DIGITS*KW-1:0] digits
);

  localparam int RW   = $clog2(ROWS);
  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    SCAN       = 3'd0,
    DEBOUNCE   = 3'd1,
    PRESSED    = 3'd2,
    HOLD       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [RW-1:0]           row_reg, row_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [COLS-1:0]         pat_reg, pat_next;
  logic [KW-1:0]           code_reg, code_next;
  logic                    held_reg, held_next;
  logic [NUM_DIGITS*KW-1:0] digits_reg, digits_next;

  logic [CW-1:0]  cnt_inc;
  logic [RW-1:0]  row_inc;
  logic [CIW-1:0] col_idx;
  logic           one_hot;
  logic [KW-1:0]  raw_code;
  logic [KW-1:0]  new_code;

`ifdef KEYPAD_HEX_MAP_EN
  if (ROWS != 4 || COLS != 4) begin : g_bad_geometry
    $error("KEYPAD_HEX_MAP_EN needs a 4x4 keypad");
  end

  function automatic logic [KW-1:0] hex_legend(input logic [KW-1:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'h1;
      4'd1:    v = 4'h2;
      4'd2:    v = 4'h3;
      4'd3:    v = 4'hA;
      4'd4:    v = 4'h4;
      4'd5:    v = 4'h5;
      4'd6:    v = 4'h6;
      4'd7:    v = 4'hB;
      4'd8:    v = 4'h7;
      4'd9:    v = 4'h8;
      4'd10:   v = 4'h9;
      4'd11:   v = 4'hC;
      4'd12:   v = 4'hF;
      4'd13:   v = 4'h0;
      4'd14:   v = 4'hE;
      default: v = 4'hD;
    endcase
    return KW'(v);
  endfunction
`endif

  // Row drive is one-cold: only the scanned row is pulled low.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_drive
    assign r_sel[gi] = (row_reg != RW'(gi));
  end

  assign key_valid = (state_reg == PRESSED);
  assign key_code  = code_reg;
  assign key_held  = held_reg;
  assign digits    = digits_reg;

  assign cnt_inc = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + CW'(1);
  assign row_inc = (row_reg >= ROW_LAST) ? '0 : row_reg + RW'(1);
  assign one_hot = (pat_reg != '0) && ((pat_reg & (pat_reg - COLS'(1))) == '0);

  always_comb begin
    col_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (pat_reg[i]) col_idx = CIW'(i);
    end
  end

  assign raw_code = KW'(int'(row_reg) * COLS + int'(col_idx));
`ifdef KEYPAD_HEX_MAP_EN
  assign new_code = hex_legend(raw_code);
`else
  assign new_code = raw_code;
`endif

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    cnt_next    = cnt_reg;
    pat_next    = pat_reg;
    code_next   = code_reg;
    held_next   = held_reg;
    digits_next = digits_reg;
    case (state_reg)
      SCAN: begin
        if (cnt_reg >= SETTLE_LAST) begin
          if (col_sync == '0) begin
            row_next = row_inc;
            cnt_next = '0;
          end else begin
            pat_next   = col_sync;
            cnt_next   = CW'(1);
            state_next = DEBOUNCE;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (col_sync == '0) begin
          row_next   = row_inc;
          cnt_next   = '0;
          state_next = SCAN;
        end else if (col_sync != pat_reg) begin
          pat_next = col_sync;
          cnt_next = CW'(1);
        end else if (cnt_reg >= DB_LAST) begin
          cnt_next = '0;
          // Code and history are committed on entry so they are valid alongside key_valid.
          if (one_hot) begin
            state_next  = PRESSED;
            code_next   = new_code;
            held_next   = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
              digits_next[i*KW +: KW] = digits_reg[(i-1)*KW +: KW];
            end
            digits_next[KW-1:0] = new_code;
          end else begin
            state_next = HOLD;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (col_sync == '0) begin
          state_next = RELEASE_DB;
          cnt_next   = CW'(1);
        end
      end
      RELEASE_DB: begin
        if (col_sync != '0) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else if (cnt_reg >= DB_LAST) begin
          held_next  = 1'b0;
          row_next   = row_inc;
          cnt_next   = '0;
          state_next = SCAN;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = SCAN;
        row_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= SCAN;
      row_reg    <= '0;
      cnt_reg    <= '0;
      pat_reg    <= '0;
      code_reg   <= '0;
      held_reg   <= 1'b0;
      digits_reg <= '0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      cnt_reg    <= cnt_next;
      pat_reg    <= pat_next;
      code_reg   <= code_next;
      held_reg   <= held_next;
      digits_reg <= digits_next;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical keypad model drives col_sync from r_sel,
// and expected codes/history come from the keypad legend and a two-entry history model.
module tb_keypad_scan_debounce;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SETTLE = 2;
  localparam int DB = 4;
  localparam int ND = 2;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [COLS-1:0] col_sync;
  logic [ROWS-1:0] r_sel;
  logic key_valid;
  logic [KW-1:0] key_code;
  logic key_held;
  logic [ND*KW-1:0] digits;

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE_CYCLES(DB), .NUM_DIGITS(ND)
  ) dut (
    .clk(clk), .reset(reset), .col_sync(col_sync), .r_sel(r_sel),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .digits(digits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;
  logic [15:0] keys = '0;
  logic use_keypad = 1'b0;
  logic [KW-1:0] exp_dig0 = '0;
  logic [KW-1:0] exp_dig1 = '0;

  function automatic logic [KW-1:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
    case (r * 4 + c)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8;  10: return 4'h9; 11: return 4'hC;
      12: return 4'hF; 13: return 4'h0; 14: return 4'hE; default: return 4'hD;
    endcase
`else
    return KW'(r * COLS + c);
`endif
  endfunction

  // Physical matrix: a column reads closed if any pressed key sits on a driven (low) row.
  function automatic logic [COLS-1:0] keypad_cols();
    logic [COLS-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!r_sel[r] && keys[r*COLS+c]) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [ROWS-1:0] rsel_of(input int r);
    logic [ROWS-1:0] one = 4'h1;
    return 4'hF ^ (one << r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_valid) begin
      pulses++;
      check("valid_not_consecutive", 32'(prev_valid), 32'd0);
    end
    prev_valid = key_valid;
    if (use_keypad) col_sync = keypad_cols();
  endtask

  task automatic set_keys(input logic [15:0] k);
    keys = k;
    if (use_keypad) col_sync = keypad_cols();
  endtask

  task automatic wait_rsel(input logic [ROWS-1:0] want, input string tag);
    int n = 0;
    while (r_sel !== want && n < 40) begin tick(); n++; end
    check(tag, 32'(r_sel), 32'(want));
  endtask

  // One single-key press: accept, hold, optional release bounce, clean release.
  task automatic do_press(input int r, input int c, input int hold_n, input int nbounce);
    int p0, n;
    logic [15:0] k;
    p0 = pulses;
    k = 16'h1 << (r * COLS + c);
    use_keypad = 1'b1;
    set_keys(k);
    n = 0;
    while (pulses == p0 && n < 100) begin tick(); n++; end
    check("press_event", 32'(pulses - p0), 32'd1);
    check("press_code", 32'(key_code), 32'(exp_code(r, c)));
    check("press_held", 32'(key_held), 32'd1);
    check("press_rsel", 32'(r_sel), 32'(rsel_of(r)));
    exp_dig1 = exp_dig0;
    exp_dig0 = exp_code(r, c);
    check("press_digits", 32'(digits), 32'({exp_dig1, exp_dig0}));
    repeat (hold_n) tick();
    check("hold_rsel", 32'(r_sel), 32'(rsel_of(r)));
    for (int b = 0; b < nbounce; b++) begin
      set_keys('0); tick();
      set_keys(k);  tick();
    end
    set_keys('0);
    n = 0;
    while (key_held && n < 20) begin tick(); n++; end
    check("release_cycles", 32'(n), 32'(DB));
    check("single_event", 32'(pulses - p0), 32'd1);
    check("release_rsel", 32'(r_sel), 32'(rsel_of((r + 1) % ROWS)));
    $display("press r=%0d c=%0d code=%0h digits=%0h", r, c, key_code, digits);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    col_sync = '0;
    repeat (3) tick();
    check("reset_rsel", 32'(r_sel), 32'(4'b1110));
    check("reset_valid", 32'(key_valid), 32'd0);
    check("reset_code", 32'(key_code), 32'd0);
    check("reset_held", 32'(key_held), 32'd0);
    check("reset_digits", 32'(digits), 32'd0);
    reset = 1'b0;

    // Idle scan: each row held SETTLE cycles, wrapping after the last row.
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("idle_rsel", 32'(r_sel), 32'(rsel_of((k / SETTLE) % ROWS)));
      check("idle_valid", 32'(key_valid), 32'd0);
    end
    $display("idle scan done");

    // Key at row2 col0 with a 0,1,0 release bounce.
    do_press(2, 0, 20, 1);

    // Chord in row0: rejected, scanning blocked until release.
    p0 = pulses;
    use_keypad = 1'b1;
    set_keys(16'h0003);
    repeat (60) tick();
    check("chord_no_event", 32'(pulses - p0), 32'd0);
    check("chord_held", 32'(key_held), 32'd0);
    check("chord_rsel", 32'(r_sel), 32'(4'b1110));
    set_keys('0);
    repeat (DB - 1) tick();
    check("chord_release_wait", 32'(r_sel), 32'(4'b1110));
    tick();
    check("chord_release_rsel", 32'(r_sel), 32'(4'b1101));
    $display("chord rejected");

    // Press bounce in row1: two cycles of 0010 then a zero.
    wait_rsel(4'b1110, "align_row0");
    wait_rsel(4'b1101, "align_row1");
    use_keypad = 1'b0;
    p0 = pulses;
    col_sync = 4'b0010;
    tick(); tick();
    check("bounce_in_debounce", 32'(r_sel), 32'(4'b1101));
    col_sync = '0;
    tick();
    check("bounce_advance", 32'(r_sel), 32'(4'b1011));
    repeat (10) tick();
    check("bounce_no_event", 32'(pulses - p0), 32'd0);
    $display("press bounce rejected");

    // Randomised single-key presses with random hold and release bounce.
    for (int i = 0; i < 6; i++)
      do_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));

    // History: keys "1" then "5" on the legend.
    do_press(0, 0, 2, 0);
    do_press(1, 1, 2, 0);
    check("history_pair", 32'(digits), 32'({exp_code(0, 0), exp_code(1, 1)}));

    // Reset in the middle of a third press.
    use_keypad = 1'b1;
    set_keys(16'h1 << (2 * COLS + 2));
    wait_rsel(4'b1011, "third_press_row");
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midreset_digits", 32'(digits), 32'd0);
    check("midreset_rsel", 32'(r_sel), 32'(4'b1110));
    check("midreset_valid", 32'(key_valid), 32'd0);
    check("midreset_held", 32'(key_held), 32'd0);
    check("midreset_code", 32'(key_code), 32'd0);
    reset = 1'b0;
    set_keys('0);
    $display("mid-press reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
